// File: rtl/axi_axis_fifo_writer.sv
// AXI4-Lite slave that queues register writes in a FIFO and plays them out as AXI4-Stream beats.
// Writes to 0x0/0x4 push a word (0x4 also marks end-of-packet); 0x8 bit 0 flushes; reads return fill and free space.
module axi_axis_fifo_writer #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,

    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic                       aw_held;
    logic                       w_held;
    logic [1:0]                 aw_off;
    logic [AXI_DATA_WIDTH-1:0]  w_data;
    logic                       bvalid_q;
    logic                       rvalid_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;

    logic [AXI_DATA_WIDTH:0]    mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]              count;

    logic full;
    logic empty;
    logic is_push_off;
    logic commit;
    logic push;
    logic flush;
    logic pop;
    logic ar_fire;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                                s_axi_araddr[AXI_ADDR_WIDTH-1:3], s_axi_araddr[1:0]};

    function automatic logic [AXI_DATA_WIDTH-1:0] to_bus(input logic [CW-1:0] v);
        return AXI_DATA_WIDTH'(v);
    endfunction

    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign is_push_off = ~aw_off[1];
    // A data write sitting in the holding registers stalls (no bvalid) until there is room.
    assign commit      = aw_held & w_held & ~bvalid_q & ~(is_push_off & full);
    assign push        = commit & is_push_off;
    assign flush       = commit & (aw_off == 2'b10) & w_data[0];
    assign pop         = ~empty & m_axis_tready;
    assign ar_fire     = s_axi_arvalid & ~rvalid_q;

    assign s_axi_awready = ~aw_held;
    assign s_axi_wready  = ~w_held;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = ~rvalid_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;

    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = mem[rd_ptr][AXI_DATA_WIDTH-1:0];
    assign m_axis_tlast  = mem[rd_ptr][AXI_DATA_WIDTH];

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (s_axi_awvalid && !aw_held) begin
                aw_held <= 1'b1;
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (s_axi_wvalid && !w_held) begin
                w_held <= 1'b1;
            end else if (commit) begin
                w_held <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= s_axi_araddr[2] ? to_bus(DEPTH_CNT - count) : to_bus(count);
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            // Flush wins over a same-cycle pop; it can never coincide with a push.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (s_axi_awvalid && !aw_held) aw_off <= s_axi_awaddr[3:2];
        if (s_axi_wvalid && !w_held)   w_data <= s_axi_wdata;
        if (push)                      mem[wr_ptr] <= {aw_off[0], w_data};
    end

endmodule

// File: tb/tb_axi_axis_fifo_writer.sv
// Randomised and directed bench for axi_axis_fifo_writer, checked against a queue model of the stream.
`timescale 1ns/1ps
module tb_axi_axis_fifo_writer;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int L     = 4;
    localparam int DEPTH = 1 << L;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0] model_q[$];
    logic [DW:0] beat;

    axi_axis_fifo_writer #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(L)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Beats leave on the next rising edge whenever valid and ready are both seen here.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            if (model_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(m_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                beat = model_q.pop_front();
                check_eq("tdata", 64'(m_axis_tdata), 64'(beat[DW-1:0]));
                check_eq("tlast", 64'(m_axis_tlast), 64'(beat[DW]));
            end
        end
    end

    task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic af, wf;
        int i;
        if (addr[3] == 1'b0) model_q.push_back({addr[2], data});
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(negedge aclk);
            af = s_axi_awvalid & s_axi_awready;
            wf = s_axi_wvalid & s_axi_wready;
            step();
            if (af) s_axi_awvalid = 1'b0;
            if (wf) s_axi_wvalid = 1'b0;
            if (!s_axi_awvalid && !s_axi_wvalid) break;
        end
        if (i == 200) check_eq("aw_w_timeout", 64'(i), 64'd0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        int i;
        for (i = 0; i < 200; i++) begin
            if (s_axi_bvalid) break;
            step();
        end
        if (i == 200) check_eq("b_timeout", 64'(i), 64'd0);
        for (int k = 0; k < hold; k++) begin
            step();
            check_eq("b_hold", 64'(s_axi_bvalid), 64'd1);
        end
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check_eq("b_clear", 64'(s_axi_bvalid), 64'd0);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int hold);
        issue_write(addr, data);
        wait_b(hold);
    endtask

    task automatic rd(input logic [AW-1:0] addr, output logic [DW-1:0] data);
        logic f;
        int i;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(negedge aclk);
            f = s_axi_arready;
            step();
            if (f) break;
        end
        if (i == 200) check_eq("ar_timeout", 64'(i), 64'd0);
        s_axi_arvalid = 1'b0;
        check_eq("rvalid_set", 64'(s_axi_rvalid), 64'd1);
        data = s_axi_rdata;
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] addr, input int exp);
        logic [DW-1:0] d;
        rd(addr, d);
        check_eq(tag, 64'(d), 64'(exp));
    endtask

    task automatic drain();
        int i;
        m_axis_tready = 1'b1;
        for (i = 0; i < 300 && model_q.size() != 0; i++) step();
        check_eq("drain_left", 64'(model_q.size()), 64'd0);
        step();
        check_eq("drained_tvalid", 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int sel;

        repeat (3) step();
        check_eq("rst_awready", 64'(s_axi_awready), 64'd1);
        check_eq("rst_wready", 64'(s_axi_wready), 64'd1);
        check_eq("rst_arready", 64'(s_axi_arready), 64'd1);
        check_eq("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check_eq("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_rdata", 64'(s_axi_rdata), 64'd0);
        areset = 1'b0;

        // Single write: bvalid and the beat appear one edge after the handshake edge.
        m_axis_tready = 1'b1;
        model_q.push_back({1'b0, 32'hDEAD_BEEF});
        s_axi_awaddr = 16'h0; s_axi_wdata = 32'hDEAD_BEEF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_eq("t1_awready_low", 64'(s_axi_awready), 64'd0);
        check_eq("t1_wready_low", 64'(s_axi_wready), 64'd0);
        check_eq("t1_bvalid_early", 64'(s_axi_bvalid), 64'd0);
        step();
        check_eq("t1_bvalid", 64'(s_axi_bvalid), 64'd1);
        check_eq("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check_eq("t1_tvalid_gone", 64'(m_axis_tvalid), 64'd0);
        rd_check("t1_count", 16'h0, 0);
        check_eq("t1_model", 64'(model_q.size()), 64'd0);

        // Fill to capacity with the stream stalled; the 17th write must wait.
        m_axis_tready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) wr(16'h0, DW'(k), 0);
        issue_write(16'h0, 32'd17);
        repeat (3) step();
        check_eq("t2_awready", 64'(s_axi_awready), 64'd0);
        check_eq("t2_wready", 64'(s_axi_wready), 64'd0);
        check_eq("t2_bvalid", 64'(s_axi_bvalid), 64'd0);
        rd_check("t2_count", 16'h0, DEPTH);
        rd_check("t2_free", 16'h4, 0);
        check_eq("t2_head", 64'(m_axis_tdata), 64'd1);
        step();
        check_eq("t2_head_stable", 64'(m_axis_tdata), 64'd1);
        m_axis_tready = 1'b1;
        wait_b(0);
        drain();

        // End-of-packet marker via offset 0x4.
        m_axis_tready = 1'b1;
        wr(16'h0, 32'hA, 0);
        wr(16'h4, 32'hB, 0);
        drain();

        // Flush discards queued words.
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) wr(16'h0, DW'(32'h50 + k), 0);
        wr(16'h8, 32'h1, 0);
        model_q.delete();
        check_eq("t4_tvalid", 64'(m_axis_tvalid), 64'd0);
        rd_check("t4_count", 16'h0, 0);
        rd_check("t4_free", 16'h4, DEPTH);

        // W ahead of AW, then a stalled B response blocks the next commit.
        m_axis_tready = 1'b0;
        model_q.push_back({1'b0, 32'h55});
        s_axi_awaddr = 16'h0; s_axi_wdata = 32'h55; s_axi_wvalid = 1'b1;
        step();
        s_axi_wvalid = 1'b0;
        check_eq("t5_wready_low", 64'(s_axi_wready), 64'd0);
        repeat (3) step();
        check_eq("t5_no_b", 64'(s_axi_bvalid), 64'd0);
        check_eq("t5_no_push", 64'(m_axis_tvalid), 64'd0);
        s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        check_eq("t5_b_early", 64'(s_axi_bvalid), 64'd0);
        step();
        check_eq("t5_bvalid", 64'(s_axi_bvalid), 64'd1);
        check_eq("t5_tvalid", 64'(m_axis_tvalid), 64'd1);
        model_q.push_back({1'b0, 32'h66});
        s_axi_wdata = 32'h66; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_eq("t5_aw2_held", 64'(s_axi_awready), 64'd0);
        rd_check("t5_count_blocked", 16'h0, 1);
        step();
        check_eq("t5_b_holds", 64'(s_axi_bvalid), 64'd1);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check_eq("t5_b_done", 64'(s_axi_bvalid), 64'd0);
        step();
        check_eq("t5_b2", 64'(s_axi_bvalid), 64'd1);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        rd_check("t5_count2", 16'h0, 2);
        drain();

        // Reset mid-operation with words queued and a response pending.
        m_axis_tready = 1'b0;
        for (int k = 0; k < 3; k++) wr(16'h0, DW'(32'h100 + k), 0);
        issue_write(16'h0, 32'h103);
        step();
        check_eq("t6_b_pending", 64'(s_axi_bvalid), 64'd1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        model_q.delete();
        check_eq("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("t6_bvalid", 64'(s_axi_bvalid), 64'd0);
        check_eq("t6_awready", 64'(s_axi_awready), 64'd1);
        check_eq("t6_wready", 64'(s_axi_wready), 64'd1);
        s_axi_bready = 1'b1;
        repeat (3) step();
        s_axi_bready = 1'b0;
        check_eq("t6_no_b", 64'(s_axi_bvalid), 64'd0);
        rd_check("t6_count", 16'h0, 0);

        // Random traffic with random backpressure on both B and the stream.
        for (int it = 0; it < 80; it++) begin
            if (model_q.size() >= DEPTH) m_axis_tready = 1'b1;
            else m_axis_tready = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 9);
            addr = (sel < 5) ? 16'h0 : (sel < 9) ? 16'h4 : 16'hC;
            data = $urandom;
            wr(addr, data, $urandom_range(0, 3));
            if (it % 10 == 9) begin
                m_axis_tready = 1'b0;
                step();
                rd_check("rnd_count", 16'h0, model_q.size());
                rd_check("rnd_free", 16'h4, DEPTH - model_q.size());
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
